// File: rtl/simon_round_ctrl.sv
// Simon Says round sequencer: plays the stored pattern, checks player entries, keeps score/best.
// Build option: define SIMON_TIMEOUT_EN to lose after TIMEOUT_TICKS ticks without an entry.
module simon_round_ctrl #(
    parameter int MAX_ROUNDS    = 39,
    parameter int SW            = 6,
    parameter int TIMEOUT_TICKS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          start,
    input  logic          enter,
    input  logic [3:0]    sw,
    output logic [SW-1:0] pat_addr,
    input  logic [3:0]    pat_data,
    output logic [3:0]    led,
    output logic          led_play,
    output logic          led_first,
    output logic [SW-1:0] score,
    output logic [SW-1:0] best,
    output logic          busy,
    output logic          game_over,
    output logic          won
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_SHOW_WAIT = 4'd2,
        ST_SHOW_ON   = 4'd3,
        ST_IN_WAIT   = 4'd4,
        ST_CHK_RD    = 4'd5,
        ST_CHECK     = 4'd6,
        ST_WIN       = 4'd7,
        ST_LOSE      = 4'd8
    } state_t;

    localparam logic [SW-1:0] SW_ZERO     = {SW{1'b0}};
    localparam logic [SW-1:0] SW_ONE      = SW'(1);
    localparam logic [SW-1:0] ROUNDS_LAST = SW'(MAX_ROUNDS);

    state_t        state_r;
    logic          dly_r;
    logic [SW-1:0] idx_r;
    logic [3:0]    step_r;
    logic [3:0]    sw_r;
    logic [SW-1:0] pat_addr_r;
    logic [SW-1:0] score_r;
    logic [SW-1:0] best_r;
    logic [3:0]    led_r;
    logic          led_play_r;
    logic          led_first_r;
    logic          busy_r;
    logic          game_over_r;
    logic          won_r;

    logic [SW-1:0] idx_inc_s;
    logic [SW-1:0] score_inc_s;
    logic          last_step_s;
    logic          match_s;
    logic          timeout_s;

    assign idx_inc_s   = idx_r + SW_ONE;
    assign score_inc_s = score_r + SW_ONE;
    assign last_step_s = (idx_r == score_r);
    assign match_s     = (pat_data == sw_r);

`ifdef SIMON_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_TICKS - 1);

    logic [TCW-1:0] tcnt_r;

    // Entry timeout counter; zero on every arrival in IN_WAIT, a same-cycle enter beats the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r <= {TCW{1'b0}};
        end else if (start || (state_r != ST_IN_WAIT)) begin
            tcnt_r <= {TCW{1'b0}};
        end else if (tick && !enter) begin
            tcnt_r <= tcnt_r + TCW'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    assign timeout_s = tick && (tcnt_r == TC_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Game sequencer: playback, entry capture, scoring and end-of-game flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            dly_r       <= 1'b0;
            idx_r       <= SW_ZERO;
            step_r      <= 4'd0;
            sw_r        <= 4'd0;
            pat_addr_r  <= SW_ZERO;
            score_r     <= SW_ZERO;
            best_r      <= SW_ZERO;
            led_r       <= 4'd0;
            led_play_r  <= 1'b0;
            led_first_r <= 1'b0;
            busy_r      <= 1'b0;
            game_over_r <= 1'b0;
            won_r       <= 1'b0;
        end else if (start) begin
            // start outranks tick/enter and aborts whatever is in progress
            state_r     <= ST_FETCH;
            dly_r       <= 1'b0;
            idx_r       <= SW_ZERO;
            pat_addr_r  <= SW_ZERO;
            score_r     <= SW_ZERO;
            led_r       <= 4'd0;
            led_play_r  <= 1'b0;
            led_first_r <= 1'b0;
            busy_r      <= 1'b1;
            game_over_r <= 1'b0;
            won_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_FETCH: begin
                    if (dly_r) begin
                        step_r  <= pat_data;
                        dly_r   <= 1'b0;
                        state_r <= ST_SHOW_WAIT;
                    end else begin
                        dly_r <= 1'b1;
                    end
                end
                ST_SHOW_WAIT: begin
                    if (tick) begin
                        led_r       <= step_r;
                        led_play_r  <= 1'b1;
                        led_first_r <= (idx_r == SW_ZERO);
                        state_r     <= ST_SHOW_ON;
                    end else begin
                        state_r <= ST_SHOW_WAIT;
                    end
                end
                ST_SHOW_ON: begin
                    if (tick) begin
                        led_r       <= 4'd0;
                        led_play_r  <= 1'b0;
                        led_first_r <= 1'b0;
                        if (last_step_s) begin
                            idx_r      <= SW_ZERO;
                            pat_addr_r <= SW_ZERO;
                            state_r    <= ST_IN_WAIT;
                        end else begin
                            idx_r      <= idx_inc_s;
                            pat_addr_r <= idx_inc_s;
                            dly_r      <= 1'b0;
                            state_r    <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_SHOW_ON;
                    end
                end
                ST_IN_WAIT: begin
                    if (enter) begin
                        sw_r    <= sw;
                        dly_r   <= 1'b0;
                        state_r <= ST_CHK_RD;
                    end else if (timeout_s) begin
                        game_over_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_LOSE;
                    end else begin
                        state_r <= ST_IN_WAIT;
                    end
                end
                ST_CHK_RD: begin
                    if (dly_r) begin
                        dly_r   <= 1'b0;
                        state_r <= ST_CHECK;
                    end else begin
                        dly_r <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!match_s) begin
                        game_over_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_LOSE;
                    end else if (!last_step_s) begin
                        idx_r      <= idx_inc_s;
                        pat_addr_r <= idx_inc_s;
                        state_r    <= ST_IN_WAIT;
                    end else begin
                        score_r <= score_inc_s;
                        best_r  <= (score_inc_s > best_r) ? score_inc_s : best_r;
                        if (score_inc_s == ROUNDS_LAST) begin
                            game_over_r <= 1'b1;
                            won_r       <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_WIN;
                        end else begin
                            idx_r      <= SW_ZERO;
                            pat_addr_r <= SW_ZERO;
                            dly_r      <= 1'b0;
                            state_r    <= ST_FETCH;
                        end
                    end
                end
                ST_WIN: begin
                    state_r <= ST_WIN;
                end
                ST_LOSE: begin
                    state_r <= ST_LOSE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    led_r       <= 4'd0;
                    led_play_r  <= 1'b0;
                    led_first_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pat_addr  = pat_addr_r;
    assign led       = led_r;
    assign led_play  = led_play_r;
    assign led_first = led_first_r;
    assign score     = score_r;
    assign best      = best_r;
    assign busy      = busy_r;
    assign game_over = game_over_r;
    assign won       = won_r;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: directed scenarios plus randomized games vs. a game-level model.
`timescale 1ns/1ps
module tb_simon_round_ctrl;

    localparam int MR  = 3;
    localparam int SWD = 6;
    localparam int TO  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick = 1'b0;
    logic           start = 1'b0;
    logic           enter = 1'b0;
    logic [3:0]     sw = 4'd0;
    logic [SWD-1:0] pat_addr;
    logic [3:0]     pat_data;
    logic [3:0]     led;
    logic           led_play;
    logic           led_first;
    logic [SWD-1:0] score;
    logic [SWD-1:0] best;
    logic           busy;
    logic           game_over;
    logic           won;

    logic [3:0] mem [0:63];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_best = 0;

    simon_round_ctrl #(.MAX_ROUNDS(MR), .SW(SWD), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .enter(enter), .sw(sw),
        .pat_addr(pat_addr), .pat_data(pat_data), .led(led), .led_play(led_play),
        .led_first(led_first), .score(score), .best(best), .busy(busy),
        .game_over(game_over), .won(won)
    );

    always #5 clk = ~clk;

    // Pattern store: one registered read stage, so data is settled by the second edge
    always @(posedge clk) pat_data <= mem[pat_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(1); tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_enter(input logic [3:0] v);
        sw = v; enter = 1'b1; cyc(1); enter = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        n_checks++; if ({pat_addr, led, led_play, led_first} !== 12'd0) begin n_fail++; $display("FAIL rst_leds: got %h want 0", {pat_addr, led, led_play, led_first}); end
        n_checks++; if ({score, best} !== 12'd0) begin n_fail++; $display("FAIL rst_score: got %h want 0", {score, best}); end
        n_checks++; if ({busy, game_over, won} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {busy, game_over, won}); end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_directed();
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
        mem[0] = 4'hA; mem[1] = 4'h3; mem[2] = 4'hF;
        pulse_start();
        n_checks++; if ({pat_addr, busy} !== {6'd0, 1'b1}) begin n_fail++; $display("FAIL dir_start: got addr=%0d busy=%b want 0/1", pat_addr, busy); end
        cyc(2);
        pulse_tick();
        n_checks++; if ({led, led_play, led_first} !== {4'hA, 1'b1, 1'b1}) begin n_fail++; $display("FAIL dir_r1_on: got %h/%b/%b want a/1/1", led, led_play, led_first); end
        pulse_tick();
        n_checks++; if ({led, led_play, led_first} !== 6'd0) begin n_fail++; $display("FAIL dir_r1_off: got %h/%b/%b want 0", led, led_play, led_first); end
        pulse_enter(4'hA);
        cyc(3);
        n_checks++; if ({score, best} !== {6'd1, 6'd1}) begin n_fail++; $display("FAIL dir_r1_score: got %0d/%0d want 1/1", score, best); end
        if (exp_best < 1) exp_best = 1;
        pulse_tick();
        n_checks++; if ({led, led_play} !== 5'd0) begin n_fail++; $display("FAIL dir_fetch_tick: got %h/%b want 0/0", led, led_play); end
        cyc(1);
        pulse_tick();
        n_checks++; if ({led, led_play, led_first} !== {4'hA, 1'b1, 1'b1}) begin n_fail++; $display("FAIL dir_r2_s0: got %h/%b/%b want a/1/1", led, led_play, led_first); end
        pulse_tick();
        n_checks++; if ({led, led_play, led_first} !== 6'd0) begin n_fail++; $display("FAIL dir_r2_s0off: got %h/%b/%b want 0", led, led_play, led_first); end
        cyc(2);
        pulse_tick();
        n_checks++; if ({led, led_play, led_first, pat_addr} !== {4'h3, 1'b1, 1'b0, 6'd1}) begin n_fail++; $display("FAIL dir_r2_s1: got %h/%b/%b addr=%0d want 3/1/0 addr=1", led, led_play, led_first, pat_addr); end
        pulse_tick();
        n_checks++; if ({led, led_play, pat_addr} !== 11'd0) begin n_fail++; $display("FAIL dir_r2_s1off: got %h/%b addr=%0d want 0", led, led_play, pat_addr); end
        pulse_enter(4'hA);
        cyc(3);
        n_checks++; if ({game_over, busy} !== 2'b01) begin n_fail++; $display("FAIL dir_r2_e0: got go=%b busy=%b want 0/1", game_over, busy); end
        pulse_enter(4'h5);
        cyc(3);
        n_checks++; if ({game_over, won, busy} !== 3'b100) begin n_fail++; $display("FAIL dir_lose_flags: got %b want 100", {game_over, won, busy}); end
        n_checks++; if ({score, best} !== {6'd1, 6'd1}) begin n_fail++; $display("FAIL dir_lose_score: got %0d/%0d want 1/1", score, best); end
        pulse_enter(4'h3);
        cyc(4);
        n_checks++; if ({score, game_over, won, busy} !== {6'd1, 3'b100}) begin n_fail++; $display("FAIL dir_lose_hold: got score=%0d flags=%b want 1/100", score, {game_over, won, busy}); end
    endtask

    task automatic test_enter_ignored();
        mem[0] = 4'($urandom_range(1, 15));
        pulse_start();
        cyc(2);
        pulse_enter(mem[0]);
        pulse_tick();
        pulse_enter(mem[0]);
        pulse_tick();
        cyc(5);
        n_checks++; if ({score, game_over, busy} !== {6'd0, 2'b01}) begin n_fail++; $display("FAIL ign_not_queued: got score=%0d go=%b busy=%b want 0/0/1", score, game_over, busy); end
        pulse_enter(mem[0]);
        cyc(3);
        n_checks++; if (score !== 6'd1) begin n_fail++; $display("FAIL ign_real_entry: got %0d want 1", score); end
        if (exp_best < 1) exp_best = 1;
    endtask

    task automatic test_start_abort();
        mem[0] = 4'($urandom_range(1, 15));
        mem[1] = 4'($urandom_range(1, 15));
        pulse_start();
        cyc(2);
        pulse_tick();
        pulse_tick();
        pulse_enter(mem[0]);
        cyc(3);
        cyc(2);
        pulse_tick();
        pulse_tick();
        cyc(2);
        pulse_tick();
        n_checks++; if ({led, led_play} !== {mem[1], 1'b1}) begin n_fail++; $display("FAIL abort_pre: got %h/%b want %h/1", led, led_play, mem[1]); end
        start = 1'b1; tick = 1'b1;
        cyc(1);
        start = 1'b0; tick = 1'b0;
        n_checks++; if ({led, led_play, led_first, pat_addr} !== 12'd0) begin n_fail++; $display("FAIL abort_leds: got %h/%b/%b addr=%0d want 0", led, led_play, led_first, pat_addr); end
        n_checks++; if ({score, best, busy} !== {6'd0, SWD'(exp_best), 1'b1}) begin n_fail++; $display("FAIL abort_score: got %0d/%0d busy=%b want 0/%0d/1", score, best, busy, exp_best); end
        cyc(2);
        pulse_tick();
        n_checks++; if ({led, led_play, led_first} !== {mem[0], 1'b1, 1'b1}) begin n_fail++; $display("FAIL abort_replay: got %h/%b/%b want %h/1/1", led, led_play, led_first, mem[0]); end
    endtask

    task automatic test_async_reset();
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if ({led, led_play, busy, score, best} !== 18'd0) begin n_fail++; $display("FAIL async_rst: got led=%h play=%b busy=%b score=%0d best=%0d want 0", led, led_play, busy, score, best); end
        exp_best = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
    endtask

`ifdef SIMON_TIMEOUT_EN
    task automatic test_timeout();
        mem[0] = 4'($urandom_range(0, 15));
        pulse_start();
        cyc(2);
        pulse_tick();
        pulse_tick();
        cyc(1);
        pulse_tick();
        cyc(1);
        pulse_tick();
        cyc(1);
        n_checks++; if ({game_over, busy} !== 2'b01) begin n_fail++; $display("FAIL to_early: got go=%b busy=%b want 0/1", game_over, busy); end
        pulse_tick();
        n_checks++; if ({game_over, won, busy, score} !== {3'b100, 6'd0}) begin n_fail++; $display("FAIL to_lose: got flags=%b score=%0d want 100/0", {game_over, won, busy}, score); end
        pulse_start();
        cyc(2);
        pulse_tick();
        pulse_tick();
        cyc(1);
        pulse_tick();
        cyc(1);
        pulse_tick();
        cyc(1);
        sw = mem[0]; tick = 1'b1; enter = 1'b1;
        cyc(1);
        tick = 1'b0; enter = 1'b0;
        cyc(3);
        n_checks++; if ({game_over, busy, score} !== {2'b01, 6'd1}) begin n_fail++; $display("FAIL to_enter_wins: got go=%b busy=%b score=%0d want 0/1/1", game_over, busy, score); end
        if (exp_best < 1) exp_best = 1;
    endtask
`else
    task automatic test_timeout();
        mem[0] = 4'($urandom_range(0, 15));
        pulse_start();
        cyc(2);
        pulse_tick();
        pulse_tick();
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            pulse_tick();
        end
        n_checks++; if ({game_over, busy, score} !== {2'b01, 6'd0}) begin n_fail++; $display("FAIL nto_wait: got go=%b busy=%b score=%0d want 0/1/0", game_over, busy, score); end
        pulse_enter(mem[0]);
        cyc(3);
        n_checks++; if (score !== 6'd1) begin n_fail++; $display("FAIL nto_entry: got %0d want 1", score); end
        if (exp_best < 1) exp_best = 1;
    endtask
`endif

    task automatic test_random_games();
        int exp_score;
        int bad;
        bit lost;
        bit exp_go;
        logic [3:0] v;
        for (int g = 0; g < 12; g++) begin
            for (int i = 0; i < 64; i++) mem[i] = 4'($urandom_range(0, 15));
            exp_score = 0;
            lost = 1'b0;
            pulse_start();
            n_checks++; if ({score, best, game_over, won} !== {6'd0, SWD'(exp_best), 2'b00}) begin n_fail++; $display("FAIL rg_start g%0d: got %0d/%0d go=%b won=%b want 0/%0d/0/0", g, score, best, game_over, won, exp_best); end
            while (!lost && exp_score < MR) begin
                cyc(2);
                for (int k = 0; k <= exp_score; k++) begin
                    pulse_tick();
                    n_checks++; if ({led, led_play, led_first, pat_addr} !== {mem[k], 1'b1, (k == 0), SWD'(k)}) begin n_fail++; $display("FAIL rg_show g%0d r%0d s%0d: got %h/%b/%b addr=%0d want %h/1/%b addr=%0d", g, exp_score + 1, k, led, led_play, led_first, pat_addr, mem[k], (k == 0), k); end
                    pulse_tick();
                    n_checks++; if ({led, led_play, led_first, busy} !== 7'd1) begin n_fail++; $display("FAIL rg_off g%0d s%0d: got %h/%b/%b busy=%b want 0/0/0 busy=1", g, k, led, led_play, led_first, busy); end
                    cyc(2);
                end
                bad = (g != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_score)) : -1;
                for (int k = 0; k <= exp_score && !lost; k++) begin
                    v = (k == bad) ? (mem[k] ^ 4'($urandom_range(1, 15))) : mem[k];
                    pulse_enter(v);
                    cyc(3);
                    if (k == bad) lost = 1'b1;
                    exp_go = lost || (k == exp_score && exp_score + 1 == MR);
                    n_checks++; if (game_over !== exp_go) begin n_fail++; $display("FAIL rg_entry g%0d e%0d: got go=%b want %b", g, k, game_over, exp_go); end
                end
                if (!lost) begin
                    exp_score++;
                    if (exp_score > exp_best) exp_best = exp_score;
                end
                n_checks++; if ({score, best} !== {SWD'(exp_score), SWD'(exp_best)}) begin n_fail++; $display("FAIL rg_score g%0d: got %0d/%0d want %0d/%0d", g, score, best, exp_score, exp_best); end
            end
            n_checks++; if ({game_over, won, busy} !== {1'b1, !lost, 1'b0}) begin n_fail++; $display("FAIL rg_end g%0d: got %b want %b", g, {game_over, won, busy}, {1'b1, !lost, 1'b0}); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
        test_reset();
        test_directed();
        test_enter_ignored();
        test_start_abort();
        test_async_reset();
        test_timeout();
        test_random_games();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
